// File: rtl/sr_chain_responder.sv
// sr_chain_responder: target-side model of a chain of NUM_WORDS serial-in /
// parallel-out shift registers. Each register is DATA_WIDTH bits wide. The
// block sits at the far end of the shift-register controller's serial bus.
// It also tracks frames and provides a registered random-access read port
// on the latched view of the chain.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   ser_clk      shift qualifier, one shift per clk edge while high
//   ser_in       serial data from the controller (LSB first)
//   ser_out      chain tail bit word[NUM_WORDS-1][0], combinational
//   rd_addr      latched-word select
//   rd_data      latched word, one cycle latency, 0 when out of range
//   word_strobe  1-cycle pulse per DATA_WIDTH completed shifts
//   frame_done   1-cycle pulse after IDLE_CYCLES consecutive low cycles
//   misaligned   last frame length not a multiple of DATA_WIDTH
//   busy         frame in progress (SHIFT or PAUSE)
module sr_chain_responder #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned NUM_WORDS   = 4,
    parameter int unsigned ADDR_WIDTH  = 2,
    parameter int unsigned IDLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ser_clk,
    input  logic                  ser_in,
    output logic                  ser_out,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  word_strobe,
    output logic                  frame_done,
    output logic                  misaligned,
    output logic                  busy
);

    localparam int unsigned CNT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] word_q  [NUM_WORDS];
    logic [DATA_WIDTH-1:0] latch_q [NUM_WORDS];
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      bit_nxt;
    logic [IDLE_W-1:0]     idle_cnt;
    logic [IDLE_W-1:0]     idle_nxt;
    logic                  do_latch;
    logic                  frame_end;
    logic                  strobe_nxt;
    logic [DATA_WIDTH-1:0] rd_nxt;

    assign ser_out = word_q[NUM_WORDS-1][0];

    // Next-state, counter and event decode
    always_comb begin
        state_nxt  = state;
        idle_nxt   = idle_cnt;
        bit_nxt    = bit_cnt;
        do_latch   = 1'b0;
        frame_end  = 1'b0;
        strobe_nxt = 1'b0;

        case (state)
            ST_IDLE: begin
                if (ser_clk) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!ser_clk) begin
                    state_nxt = ST_PAUSE;
                    do_latch  = 1'b1;
                    idle_nxt  = IDLE_W'(1);
                end
            end
            ST_PAUSE: begin
                if (ser_clk) begin
                    state_nxt = ST_SHIFT;
                    idle_nxt  = '0;
                end else if (idle_cnt == IDLE_W'(IDLE_CYCLES - 1)) begin
                    state_nxt = ST_IDLE;
                    frame_end = 1'b1;
                    idle_nxt  = '0;
                end else begin
                    idle_nxt = idle_cnt + IDLE_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                idle_nxt  = '0;
            end
        endcase

        // Shifts happen in every state; frame end only occurs with ser_clk low
        if (ser_clk) begin
            if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                bit_nxt    = '0;
                strobe_nxt = 1'b1;
            end else begin
                bit_nxt = bit_cnt + CNT_W'(1);
            end
        end else if (frame_end) begin
            bit_nxt = '0;
        end
    end

    // Read mux over the latched view; unmatched addresses read as zero
    always_comb begin
        rd_nxt = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (rd_addr == ADDR_WIDTH'(i)) begin
                rd_nxt = latch_q[i];
            end
        end
    end

    // FSM state and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_nxt;
            idle_cnt <= idle_nxt;
        end
    end

    // Shift stage: word 0 takes the wire, each word feeds the next one's MSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                word_q[i] <= '0;
            end
        end else if (ser_clk) begin
            word_q[0] <= {ser_in, word_q[0][DATA_WIDTH-1:1]};
            for (int i = 1; i < NUM_WORDS; i++) begin
                word_q[i] <= {word_q[i-1][0], word_q[i][DATA_WIDTH-1:1]};
            end
        end
    end

    // Output latch, captured when shifting stops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                latch_q[i] <= '0;
            end
        end else if (do_latch) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                latch_q[i] <= word_q[i];
            end
        end
    end

    // Registered status outputs and read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data     <= '0;
            word_strobe <= 1'b0;
            frame_done  <= 1'b0;
            misaligned  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rd_data     <= rd_nxt;
            word_strobe <= strobe_nxt;
            frame_done  <= frame_end;
            busy        <= (state_nxt != ST_IDLE);
            if (frame_end) begin
                misaligned <= (bit_cnt != '0);
            end
        end
    end

endmodule

// File: tb/tb_sr_chain_responder.sv
// Self-checking bench for sr_chain_responder: a directed vector table, hand
// sequences for multi-cycle corners, then bursty random traffic. All of it is
// compared against a frame-level reference model.
module tb_sr_chain_responder;

    localparam int DW   = 8;
    localparam int NW   = 4;
    localparam int NW3  = 3;
    localparam int IDLE = 4;

    logic       clk;
    logic       rst_n;
    logic       ser_clk;
    logic       ser_in;
    logic [1:0] rd_addr;
    logic       ser_out,  ser_out3;
    logic [7:0] rd_data,  rd_data3;
    logic       word_strobe, word_strobe3;
    logic       frame_done,  frame_done3;
    logic       misaligned,  misaligned3;
    logic       busy,        busy3;

    sr_chain_responder #(
        .DATA_WIDTH(8), .NUM_WORDS(4), .ADDR_WIDTH(2), .IDLE_CYCLES(4)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .ser_clk(ser_clk), .ser_in(ser_in),
        .ser_out(ser_out), .rd_addr(rd_addr), .rd_data(rd_data),
        .word_strobe(word_strobe), .frame_done(frame_done),
        .misaligned(misaligned), .busy(busy)
    );

    // Three-word chain sharing the bus, exercises out-of-range reads
    sr_chain_responder #(
        .DATA_WIDTH(8), .NUM_WORDS(3), .ADDR_WIDTH(2), .IDLE_CYCLES(4)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n), .ser_clk(ser_clk), .ser_in(ser_in),
        .ser_out(ser_out3), .rd_addr(rd_addr), .rd_data(rd_data3),
        .word_strobe(word_strobe3), .frame_done(frame_done3),
        .misaligned(misaligned3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int strobe_cnt = 0;

    // Reference model: whole chain as one flat bit vector, first word at the top
    logic [NW*DW-1:0]  m_chain;
    logic [NW3*DW-1:0] m_chain3;
    logic [7:0]        m_lat  [NW];
    logic [7:0]        m_lat3 [NW3];
    int                m_fbits;
    int                m_low;
    bit                m_in_frame;
    logic              e_strobe, e_done, e_mis, e_busy;
    logic [7:0]        e_rd, e_rd3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_chain    = '0;
        m_chain3   = '0;
        for (int i = 0; i < NW; i++)  m_lat[i]  = '0;
        for (int i = 0; i < NW3; i++) m_lat3[i] = '0;
        m_fbits    = 0;
        m_low      = 0;
        m_in_frame = 0;
        e_strobe   = 0;
        e_done     = 0;
        e_mis      = 0;
        e_busy     = 0;
        e_rd       = '0;
        e_rd3      = '0;
    endtask

    // One clock: drive, advance the model with the same inputs, compare
    task automatic step(input logic sc, input logic si, input logic [1:0] a);
        ser_clk = sc;
        ser_in  = si;
        rd_addr = a;
        @(posedge clk);
        e_rd  = m_lat[a];
        e_rd3 = '0;
        if (int'(a) < NW3) e_rd3 = m_lat3[a];
        e_strobe = 0;
        e_done   = 0;
        if (sc) begin
            m_chain    = {si, m_chain[NW*DW-1:1]};
            m_chain3   = {si, m_chain3[NW3*DW-1:1]};
            m_fbits++;
            e_strobe   = ((m_fbits % DW) == 0);
            m_in_frame = 1;
            m_low      = 0;
        end else if (m_in_frame) begin
            m_low++;
            if (m_low == 1) begin
                for (int i = 0; i < NW; i++)  m_lat[i]  = m_chain[(NW-1-i)*DW +: DW];
                for (int i = 0; i < NW3; i++) m_lat3[i] = m_chain3[(NW3-1-i)*DW +: DW];
            end
            if (m_low == IDLE) begin
                e_done     = 1;
                e_mis      = ((m_fbits % DW) != 0);
                m_fbits    = 0;
                m_in_frame = 0;
            end
        end
        e_busy = m_in_frame;
        #1;
        chk("ser_out",     32'(ser_out),     32'(m_chain[0]));
        chk("rd_data",     32'(rd_data),     32'(e_rd));
        chk("word_strobe", 32'(word_strobe), 32'(e_strobe));
        chk("frame_done",  32'(frame_done),  32'(e_done));
        chk("misaligned",  32'(misaligned),  32'(e_mis));
        chk("busy",        32'(busy),        32'(e_busy));
        chk("ser_out3",    32'(ser_out3),    32'(m_chain3[0]));
        chk("rd_data3",    32'(rd_data3),    32'(e_rd3));
        chk("strobe3",     32'(word_strobe3), 32'(e_strobe));
        chk("done3",       32'(frame_done3), 32'(e_done));
        chk("mis3",        32'(misaligned3), 32'(e_mis));
        chk("busy3",       32'(busy3),       32'(e_busy));
        if (word_strobe) strobe_cnt++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int k = 0; k < DW; k++) step(1'b1, b[k], 2'd0);
    endtask

    task automatic lows(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 2'd0);
    endtask

    typedef struct {
        logic       sclk;
        logic       sin;
        logic [1:0] addr;
        logic       e_strobe;
        logic       e_done;
        logic       e_busy;
        logic       e_mis;
        logic [7:0] e_rd;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [7:0] emitted;
        int         rem;
        logic       sc;

        // Single word 0x07 then idle: strobe after 8th shift, done after 4th low
        tbl[0]  = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[3]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[4]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[5]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[6]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[7]  = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[8]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[9]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h07};
        tbl[10] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h07};
        tbl[11] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h07};
        tbl[12] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h07};
        tbl[13] = '{1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

        rst_n   = 1'b0;
        ser_clk = 1'b0;
        ser_in  = 1'b0;
        rd_addr = 2'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_data", 32'(rd_data), 32'h0);
        chk("rst_busy",    32'(busy),    32'h0);
        chk("rst_ser_out", 32'(ser_out), 32'h0);
        rst_n = 1'b1;

        // Vector table
        for (int r = 0; r < 14; r++) begin
            step(tbl[r].sclk, tbl[r].sin, tbl[r].addr);
            chk("tbl_strobe", 32'(word_strobe), 32'(tbl[r].e_strobe));
            chk("tbl_done",   32'(frame_done),  32'(tbl[r].e_done));
            chk("tbl_busy",   32'(busy),        32'(tbl[r].e_busy));
            chk("tbl_mis",    32'(misaligned),  32'(tbl[r].e_mis));
            chk("tbl_rd",     32'(rd_data),     32'(tbl[r].e_rd));
        end

        // Full chain: 0x07, 0x63, 0x99, 0x3C back-to-back
        strobe_cnt = 0;
        send_byte(8'h07);
        send_byte(8'h63);
        send_byte(8'h99);
        send_byte(8'h3C);
        chk("chain_strobes", 32'(strobe_cnt), 32'd4);
        lows(5);
        step(1'b0, 1'b0, 2'd0); chk("chain_w0", 32'(rd_data), 32'h3C);
        step(1'b0, 1'b0, 2'd1); chk("chain_w1", 32'(rd_data), 32'h99);
        step(1'b0, 1'b0, 2'd2); chk("chain_w2", 32'(rd_data), 32'h63);
        chk("chain3_w2", 32'(rd_data3), 32'h63);
        step(1'b0, 1'b0, 2'd3); chk("chain_w3", 32'(rd_data), 32'h07);
        chk("oor_rd3", 32'(rd_data3), 32'h00);
        emitted = '0;
        for (int k = 0; k < DW; k++) begin
            emitted[k] = ser_out;
            step(1'b1, 1'b0, 2'd0);
        end
        chk("tail_emit", 32'(emitted), 32'h07);
        lows(2);
        chk("flush_w0", 32'(rd_data), 32'h00);
        step(1'b0, 1'b0, 2'd3); chk("flush_w3", 32'(rd_data), 32'h63);
        lows(3);

        // Misaligned frame, then aligned frame, then misaligned again
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 2'd0);
        lows(4);
        chk("mis5_done", 32'(frame_done), 32'h1);
        chk("mis5_flag", 32'(misaligned), 32'h1);
        send_byte(8'hA5);
        lows(4);
        chk("al8_done", 32'(frame_done), 32'h1);
        chk("al8_flag", 32'(misaligned), 32'h0);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 2'd0);
        lows(4);
        chk("mis5b_flag", 32'(misaligned), 32'h1);

        // Async reset mid-frame clears everything, no frame_done afterwards
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 2'd0);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy",    32'(busy),        32'h0);
        chk("mrst_mis",     32'(misaligned),  32'h0);
        chk("mrst_rd",      32'(rd_data),     32'h0);
        chk("mrst_ser_out", 32'(ser_out),     32'h0);
        chk("mrst_done",    32'(frame_done),  32'h0);
        model_reset();
        ser_clk = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int a = 0; a < NW; a++) begin
            step(1'b0, 1'b0, 2'(a));
            chk("mrst_rd_addr", 32'(rd_data), 32'h0);
        end
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 2'd0);
            chk("mrst_no_done", 32'(frame_done), 32'h0);
        end

        // Pause mid-word: 3 shifts, 2 lows, 5 shifts
        strobe_cnt = 0;
        step(1'b1, 1'b1, 2'd0);
        step(1'b1, 1'b0, 2'd0);
        step(1'b1, 1'b1, 2'd0);
        step(1'b0, 1'b0, 2'd0); chk("gap_done1", 32'(frame_done), 32'h0);
        step(1'b0, 1'b0, 2'd0); chk("gap_done2", 32'(frame_done), 32'h0);
        chk("gap_partial", 32'(rd_data), 32'hA0);
        step(1'b1, 1'b1, 2'd0);
        step(1'b1, 1'b1, 2'd0);
        step(1'b1, 1'b0, 2'd0);
        step(1'b1, 1'b0, 2'd0);
        step(1'b1, 1'b0, 2'd0);
        chk("gap_strobes", 32'(strobe_cnt), 32'd1);
        lows(4);
        chk("gap_final_done", 32'(frame_done), 32'h1);
        chk("gap_final_mis",  32'(misaligned), 32'h0);
        step(1'b0, 1'b0, 2'd0); chk("gap_word", 32'(rd_data), 32'h1D);

        // Bursty random traffic against the model
        rem = 0;
        sc  = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (rem == 0) begin
                sc  = 1'($urandom_range(0, 1));
                rem = $urandom_range(1, 12);
            end
            rem--;
            step(sc, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sr_chain_responder.md
Name: sr_chain_responder

Overview:
- Target-side model of a chain of NUM_WORDS serial-in/parallel-out shift registers, each DATA_WIDTH bits wide.
- It sits at the far end of the serial bus driven by the shift-register controller and replaces discrete latched shift registers in the design:
  - receives the controller's ser_out and ser_clk;
  - returns the chain tail on ser_out, which feeds the controller's ser_in.
- Adds frame tracking for the controller and for debug: word boundaries, end-of-frame detection and misalignment detection.
- Adds a random-access parallel read port on the latched (output-register) view.

Parameters:
- DATA_WIDTH, 8, bits per word / per shift-register stage.
- NUM_WORDS, 4, number of chained words.
- ADDR_WIDTH, 2, width of rd_addr (≥ clog2(NUM_WORDS)).
- IDLE_CYCLES, 4, consecutive ser_clk-low cycles (counted from pause entry) that end a frame; must be ≥ 2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ser_clk  in  1  synchronous shift qualifier; one shift per clk edge while 1.
- ser_in  in  1  serial data from controller ser_out.
- ser_out  out  1  chain tail bit, word[NUM_WORDS-1][0]; goes to controller ser_in.
- rd_addr  in  ADDR_WIDTH  latched-word select.
- rd_data  out  DATA_WIDTH  latched word, registered.
- word_strobe  out  1  1-cycle pulse per DATA_WIDTH completed shifts.
- frame_done  out  1  1-cycle pulse at end of frame.
- misaligned  out  1  last frame bit count not a multiple of DATA_WIDTH.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - all shift words, latch words, bit_cnt and idle_cnt are cleared to 0;
  - FSM goes to IDLE;
  - rd_data, word_strobe, frame_done, misaligned and busy are all 0.
- Shift, on a clk edge with ser_clk=1, in every state:
  - word[0] <= {ser_in, word[0][DATA_WIDTH-1:1]};
  - word[i] <= {word[i-1][0], word[i][DATA_WIDTH-1:1]} for i>0;
  - net effect: LSB-first on the wire, and the first word sent ends up in the highest index.
- ser_out: combinational from word[NUM_WORDS-1][0] (shift stage, not latch).
- bit_cnt: counts 0..DATA_WIDTH-1.
  - Increments on each shift and wraps to 0.
  - The shift that wraps it registers word_strobe=1 for the next cycle.
- FSM states IDLE / SHIFT / PAUSE:
  - IDLE:
    - ser_clk=1 → SHIFT (the shift happens on this edge).
  - SHIFT:
    - ser_clk=0 → PAUSE; latch[i] <= word[i] for all i on this edge;
    - idle_cnt <= 1.
  - PAUSE:
    - ser_clk=1 → SHIFT; shift occurs; bit_cnt is kept (frame continues); idle_cnt <= 0.
    - otherwise idle_cnt increments.
    - When idle_cnt reaches IDLE_CYCLES-1 with ser_clk=0 → IDLE, and on the same edge:
      - frame_done <= 1 (visible next cycle);
      - misaligned <= (bit_cnt != 0);
      - bit_cnt <= 0.
    - Frame end is therefore flagged after IDLE_CYCLES consecutive ser_clk-low cycles.
- misaligned: holds its value until the next frame end.
- busy: 1 in SHIFT and PAUSE.
- rd_data:
  - on each edge, rd_data <= latch[rd_addr], one-cycle latency;
  - rd_addr ≥ NUM_WORDS → rd_data <= 0.
- Simultaneous events:
  - A shift on the same edge as the SHIFT→PAUSE latch cannot occur (that transition requires ser_clk=0).
  - The latch captures the shift-stage value after the final shift.
- Async reset mid-frame: everything clears immediately; no frame_done is issued.

Test Plan:
- Reset: rst_n=0 mid-run, then release →
  - rd_data=0 for addr 0..3;
  - ser_out, busy, misaligned and frame_done all 0.
- Single word: drive 8 shifts of 0x07 (ser_in 1,1,1,0,0,0,0,0), then ser_clk low →
  - exactly one word_strobe, one cycle after the 8th shift;
  - rd_addr=0 reads 0x07 one cycle after the latch;
  - frame_done pulses after 4 low cycles; misaligned=0; busy drops.
- Full chain: send 0x07, 0x63, 0x99, 0x3C back-to-back (32 shifts) →
  - latch[3..0] = 0x07, 0x63, 0x99, 0x3C;
  - 4 word_strobes;
  - then shift 8 more zeros: ser_out emits 0x07 LSB-first and latch[0]=0x00.
- Misalignment: 5 shifts then idle →
  - frame_done with misaligned=1;
  - a following aligned 8-shift frame → misaligned=0.
- Pause mid-word: 3 shifts, 2 low cycles, 5 shifts →
  - no frame_done during the gap;
  - latch shows the partial value during the pause;
  - one word_strobe; final frame_done with misaligned=0.
- Out-of-range read: rd_addr ≥ NUM_WORDS (e.g. NUM_WORDS=3 with ADDR_WIDTH=2) → rd_data=0.
